// File: rtl/dual_port_memory_ctrl_if.sv
// Port bundle for dual_port_memory_ctrl: write port, read port, clear request and status.
// The master drives the strobes. The memory holds no ready signal: busy=1 means strobes are dropped.
interface dual_port_memory_ctrl_if #(
   parameter int Width = 8,
   parameter int AW    = 4,
   parameter int NB    = 1
);
   logic             wr_enable;
   logic [AW-1:0]    wr_address;
   logic [Width-1:0] wr_data;
   logic [NB-1:0]    wr_byte_en;
   logic             rd_enable;
   logic [AW-1:0]    rd_address;
   logic [Width-1:0] rd_data;
   logic             rd_valid;
   logic             clear_req;
   logic             busy;
   logic             state_dbg;

   modport master (
      output wr_enable, wr_address, wr_data, wr_byte_en, rd_enable, rd_address, clear_req,
      input  rd_data, rd_valid, busy, state_dbg
   );
   modport slave (
      input  wr_enable, wr_address, wr_data, wr_byte_en, rd_enable, rd_address, clear_req,
      output rd_data, rd_valid, busy, state_dbg
   );
endinterface

// File: rtl/dual_port_memory_ctrl.sv
// Simple-dual-port memory with byte-lane writes, 1/2-cycle reads, a collision policy,
// and a clear sequencer that zeroes the array after reset or on request.
module dual_port_memory_ctrl #(
   parameter int Width        = 8,
   parameter int Depth        = 16,
   parameter int ByteW        = 8,
   parameter int RdLatency    = 1,
   parameter int RdMode       = 0,
   parameter int ClearOnReset = 1,
   localparam int AW          = $clog2(Depth),
   localparam int NB          = Width / ByteW
) (
   input logic                  clk,
   input logic                  rst,
   dual_port_memory_ctrl_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

   localparam logic [AW:0]   DepthW   = (AW + 1)'(Depth);
   localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);
   localparam state_e        RstState = (ClearOnReset != 0) ? CLEAR : IDLE;

   logic [Width-1:0] mem_q [Depth];

   state_e           state_q, state_d;
   logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
   logic             busy_q, busy_d;
   logic             s1_valid_q, s1_valid_d;
   logic [Width-1:0] s1_data_q, s1_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic [Width-1:0] rd_data_q, rd_data_d;

   logic             wr_in_range, rd_in_range, wr_ok, rd_ok;
   logic [Width-1:0] wr_old, wr_merged, rd_word;

   always_comb begin
      wr_in_range = {1'b0, bus.wr_address} < DepthW;
      rd_in_range = {1'b0, bus.rd_address} < DepthW;
      wr_ok       = bus.wr_enable && (state_q == IDLE) && wr_in_range;
      rd_ok       = bus.rd_enable && (state_q == IDLE);
      wr_old      = wr_in_range ? mem_q[bus.wr_address] : '0;
      wr_merged   = wr_old;
      for (int i = 0; i < NB; i++) begin
         if (bus.wr_byte_en[i]) wr_merged[i*ByteW +: ByteW] = bus.wr_data[i*ByteW +: ByteW];
      end
      // Write-first collisions forward the merged word; read-first sees the array before the edge.
      if (!rd_in_range) rd_word = '0;
      else if ((RdMode != 0) && wr_ok && (bus.wr_address == bus.rd_address)) rd_word = wr_merged;
      else rd_word = mem_q[bus.rd_address];
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.clear_req) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == LastAddr) begin
               state_d   = IDLE;
               clr_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == CLEAR);

      // Pipeline advances unconditionally so a read accepted just before a sweep still completes.
      s1_valid_d = rd_ok;
      s1_data_d  = rd_ok ? rd_word : s1_data_q;
      if (RdLatency == 2) begin
         rd_valid_d = s1_valid_q;
         rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
      end else begin
         rd_valid_d = rd_ok;
         rd_data_d  = rd_ok ? rd_word : rd_data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RstState;
         clr_cnt_q  <= '0;
         busy_q     <= (ClearOnReset != 0);
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         busy_q     <= busy_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Array contents survive reset; only the sweep zeroes them.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) mem_q[clr_cnt_q] <= '0;
      else if (wr_ok) mem_q[bus.wr_address] <= wr_merged;
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_dual_port_memory_ctrl.sv
// Directed bench: two instances share stimulus; A is 1-cycle read-first, B is 2-cycle write-first.
module tb_dual_port_memory_ctrl;
   localparam int W  = 32;
   localparam int D  = 16;
   localparam int AW = 4;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          wr_enable  = 1'b0;
   logic [AW-1:0] wr_address = '0;
   logic [W-1:0]  wr_data    = '0;
   logic [NB-1:0] wr_byte_en = '0;
   logic          rd_enable  = 1'b0;
   logic [AW-1:0] rd_address = '0;
   logic          clear_req  = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] pat [8] = '{32'h0101_1001, 32'h0202_2002, 32'h0303_3003, 32'h0404_4004,
                             32'h0505_5005, 32'h0606_6006, 32'h0707_7007, 32'h0808_8008};

   dual_port_memory_ctrl_if #(.Width(W), .AW(AW), .NB(NB)) if_a ();
   dual_port_memory_ctrl_if #(.Width(W), .AW(AW), .NB(NB)) if_b ();

   assign if_a.wr_enable  = wr_enable;   assign if_b.wr_enable  = wr_enable;
   assign if_a.wr_address = wr_address;  assign if_b.wr_address = wr_address;
   assign if_a.wr_data    = wr_data;     assign if_b.wr_data    = wr_data;
   assign if_a.wr_byte_en = wr_byte_en;  assign if_b.wr_byte_en = wr_byte_en;
   assign if_a.rd_enable  = rd_enable;   assign if_b.rd_enable  = rd_enable;
   assign if_a.rd_address = rd_address;  assign if_b.rd_address = rd_address;
   assign if_a.clear_req  = clear_req;   assign if_b.clear_req  = clear_req;

   dual_port_memory_ctrl #(.Width(W), .Depth(D), .ByteW(8), .RdLatency(1), .RdMode(0),
                           .ClearOnReset(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   dual_port_memory_ctrl #(.Width(W), .Depth(D), .ByteW(8), .RdLatency(2), .RdMode(1),
                           .ClearOnReset(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] be);
      wr_enable = 1'b1; wr_address = a; wr_data = d; wr_byte_en = be;
      cycle();
      wr_enable = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
      rd_enable = 1'b1; rd_address = a;
      cycle();
      rd_enable = 1'b0;
      check_bit({tag, "_a_valid"}, if_a.rd_valid, 1'b1);
      check({tag, "_a_data"}, if_a.rd_data, exp);
      check_bit({tag, "_b_early"}, if_b.rd_valid, 1'b0);
      cycle();
      check_bit({tag, "_b_valid"}, if_b.rd_valid, 1'b1);
      check({tag, "_b_data"}, if_b.rd_data, exp);
      check_bit({tag, "_a_pulse"}, if_a.rd_valid, 1'b0);
   endtask

   task automatic collide(input string tag, input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [NB-1:0] be, input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
      wr_enable = 1'b1; wr_address = a; wr_data = d; wr_byte_en = be;
      rd_enable = 1'b1; rd_address = a;
      cycle();
      wr_enable = 1'b0; rd_enable = 1'b0;
      check({tag, "_a_data"}, if_a.rd_data, exp_a);
      cycle();
      check({tag, "_b_data"}, if_b.rd_data, exp_b);
   endtask

   // Sixteen edges after the first edge of a sweep; busy must drop exactly on the last one.
   task automatic busy_window(input string tag);
      for (int k = 1; k <= D; k++) begin
         cycle();
         check_bit({tag, "_busy_a"}, if_a.busy, k < D);
         check_bit({tag, "_busy_b"}, if_b.busy, k < D);
      end
   endtask

   initial begin
      // Reset state
      cycle();
      cycle();
      check_bit("rst_busy_a", if_a.busy, 1'b1);
      check_bit("rst_busy_b", if_b.busy, 1'b1);
      check_bit("rst_state_a", if_a.state_dbg, 1'b1);
      check_bit("rst_valid_a", if_a.rd_valid, 1'b0);
      check_bit("rst_valid_b", if_b.rd_valid, 1'b0);
      check("rst_data_a", if_a.rd_data, 32'h0);
      check("rst_data_b", if_b.rd_data, 32'h0);
      rst = 1'b0;
      busy_window("rst_sweep");
      for (int i = 0; i < D; i++) read_check("clr_read", AW'(i), 32'h0);

      // Byte-enable merge and empty lane mask
      write_word(4'd5, 32'hAABB_CCDD, 4'b1111);
      write_word(4'd5, 32'h1122_3344, 4'b0101);
      read_check("be_merge", 4'd5, 32'hAA22_CC44);
      write_word(4'd5, 32'hFFFF_FFFF, 4'b0000);
      read_check("be_none", 4'd5, 32'hAA22_CC44);

      // Collisions: A returns the old word, B the merged word
      write_word(4'd3, 32'h0000_0012, 4'b1111);
      collide("coll_full", 4'd3, 32'h0000_0034, 4'b1111, 32'h0000_0012, 32'h0000_0034);
      read_check("coll_after", 4'd3, 32'h0000_0034);
      collide("coll_part", 4'd3, 32'h0000_AB00, 4'b0010, 32'h0000_0034, 32'h0000_AB34);
      read_check("coll_part_after", 4'd3, 32'h0000_AB34);

      // Back-to-back reads at full throughput
      for (int i = 0; i < 8; i++) write_word(AW'(i), pat[i], 4'b1111);
      for (int j = 0; j < 10; j++) begin
         rd_enable  = (j < 8);
         rd_address = AW'(j);
         cycle();
         check_bit("tput_a_valid", if_a.rd_valid, j < 8);
         check_bit("tput_b_valid", if_b.rd_valid, (j >= 1) && (j < 9));
         if (j < 8) check("tput_a_data", if_a.rd_data, pat[j]);
         if ((j >= 1) && (j < 9)) check("tput_b_data", if_b.rd_data, pat[j-1]);
      end
      rd_enable = 1'b0;

      // Clear under continuous reads, with a second request and writes during the sweep
      rd_enable = 1'b1; rd_address = 4'd0; clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      check_bit("clr_last_read_a", if_a.rd_valid, 1'b1);
      check("clr_last_data_a", if_a.rd_data, pat[0]);
      check_bit("clr_busy_start", if_a.busy, 1'b1);
      wr_enable = 1'b1; wr_address = 4'd0; wr_data = 32'hFFFF_FFFF; wr_byte_en = 4'hF;
      for (int k = 1; k <= D; k++) begin
         clear_req = (k == 8);
         cycle();
         check_bit("clr_busy_a", if_a.busy, k < D);
         check_bit("clr_busy_b", if_b.busy, k < D);
         check_bit("clr_quiet_a", if_a.rd_valid, 1'b0);
         check_bit("clr_valid_b", if_b.rd_valid, k == 1);
         if (k == 1) check("clr_last_data_b", if_b.rd_data, pat[0]);
         if (k == D) check("clr_hold_a", if_a.rd_data, pat[0]);
      end
      clear_req = 1'b0; wr_enable = 1'b0;
      cycle();
      check_bit("clr_first_acc_a", if_a.rd_valid, 1'b1);
      check("clr_first_data_a", if_a.rd_data, 32'h0);
      check_bit("clr_not_busy", if_a.busy, 1'b0);
      rd_enable = 1'b0;
      cycle();
      check_bit("clr_first_acc_b", if_b.rd_valid, 1'b1);
      check("clr_first_data_b", if_b.rd_data, 32'h0);
      for (int i = 0; i < D; i++) read_check("clr2_read", AW'(i), 32'h0);

      // Reset in the middle of a sweep
      write_word(4'd2, 32'h5A5A_5A5A, 4'b1111);
      read_check("pre_rst", 4'd2, 32'h5A5A_5A5A);
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      repeat (9) cycle();
      rst = 1'b1;
      #1;
      check_bit("mid_rst_valid_a", if_a.rd_valid, 1'b0);
      check_bit("mid_rst_valid_b", if_b.rd_valid, 1'b0);
      check("mid_rst_data_a", if_a.rd_data, 32'h0);
      check("mid_rst_data_b", if_b.rd_data, 32'h0);
      check_bit("mid_rst_busy", if_a.busy, 1'b1);
      cycle();
      rst = 1'b0;
      busy_window("mid_rst_sweep");
      read_check("post_rst2", 4'd2, 32'h0);
      read_check("post_rst9", 4'd9, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
